// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
// ifetch_unit : PC, single-outstanding imem handshake, IF/ID bubble/redirect
// Rev 1.0
// ============================================================================
module ifetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800,
  parameter logic [4:0]  HALT_OPC  = 5'b00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_rd,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_done,
  output logic [15:0] instr_out,
  output logic [15:0] nextPC_out,
  output logic        ifid_en,
  output logic        halted
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    WAIT_DS = 2'd1,
    HALT    = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] pc, pc_nxt;
  logic [15:0] ibuf, ibuf_nxt;
  logic [15:0] redir_pc, redir_nxt;
  logic        squash, squash_nxt;
  logic [15:0] pc_plus2;

  assign pc_plus2   = pc + 16'd2;
  assign nextPC_out = pc_plus2;
  assign imem_addr  = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      ibuf     <= NOP_INSTR;
      redir_pc <= RESET_PC;
      squash   <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      ibuf     <= ibuf_nxt;
      redir_pc <= redir_nxt;
      squash   <= squash_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    ibuf_nxt   = ibuf;
    redir_nxt  = redir_pc;
    squash_nxt = squash;
    imem_rd    = 1'b0;
    instr_out  = NOP_INSTR;
    ifid_en    = !stall_in;
    halted     = 1'b0;

    unique case (state)
      FETCH: begin
        imem_rd = 1'b1;
        if (redirect) begin
          ifid_en = 1'b1;
          // An in-flight request cannot be withdrawn: remember the target
          // and drop whatever the memory eventually returns.
          if (imem_done) begin
            pc_nxt     = redirect_pc;
            squash_nxt = 1'b0;
          end else begin
            redir_nxt  = redirect_pc;
            squash_nxt = 1'b1;
          end
        end else if (imem_done) begin
          if (squash) begin
            pc_nxt     = redir_pc;
            squash_nxt = 1'b0;
          end else if (!stall_in) begin
            instr_out = imem_rdata;
            ifid_en   = 1'b1;
            pc_nxt    = pc_plus2;
            state_nxt = (imem_rdata[15:11] == HALT_OPC) ? HALT : FETCH;
          end else begin
            ibuf_nxt  = imem_rdata;
            ifid_en   = 1'b0;
            state_nxt = WAIT_DS;
          end
        end
      end

      WAIT_DS: begin
        instr_out = ibuf;
        if (redirect) begin
          instr_out = NOP_INSTR;
          ifid_en   = 1'b1;
          ibuf_nxt  = NOP_INSTR;
          pc_nxt    = redirect_pc;
          state_nxt = FETCH;
        end else if (!stall_in) begin
          pc_nxt    = pc_plus2;
          state_nxt = (ibuf[15:11] == HALT_OPC) ? HALT : FETCH;
        end
      end

      HALT: begin
        halted = 1'b1;
        if (redirect) begin
          ifid_en   = 1'b1;
          pc_nxt    = redirect_pc;
          state_nxt = FETCH;
        end
      end

      default: begin
        state_nxt = FETCH;
      end
    endcase

    // State is already at its reset value; keep the outputs quiet too.
    if (rst) begin
      imem_rd   = 1'b0;
      ifid_en   = 1'b0;
      instr_out = NOP_INSTR;
      halted    = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// ============================================================================
// tb_ifetch_unit : scoreboard bench with a variable-latency imem model
// Rev 1.0
// ============================================================================
module tb_ifetch_unit;

  logic        clk;
  logic        rst;
  logic        stall_in;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_done;
  logic [15:0] instr_out;
  logic [15:0] nextPC_out;
  logic        ifid_en;
  logic        halted;

  logic        mem_on;
  int          lat;
  int          wait_cnt;
  logic [15:0] halt_addr;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] npc;
  } exp_t;
  exp_t sb_q[$];

  ifetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .stall_in   (stall_in),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_rd    (imem_rd),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_done  (imem_done),
    .instr_out  (instr_out),
    .nextPC_out (nextPC_out),
    .ifid_en    (ifid_en),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a, input logic [15:0] h);
    if (a == h)          return 16'h0000;
    else if (a == 16'd0) return 16'h1111;
    else if (a == 16'd2) return 16'h2222;
    else if (a == 16'd4) return 16'h3333;
    else                 return {4'hA, a[11:0]};
  endfunction

  assign imem_rdata = mem_word(imem_addr, halt_addr);
  assign imem_done  = mem_on && imem_rd && (wait_cnt >= lat);

  always @(posedge clk) begin
    if (rst || !imem_rd || imem_done) wait_cnt <= 0;
    else                              wait_cnt <= wait_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [15:0] instr, input logic [15:0] npc);
    sb_q.push_back({instr, npc});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst      = 1'b1;
    stall_in = 1'b1;
    mem_on   = 1'b0;
    redirect = 1'b0;
    lat      = 0;
    step();
    rst = 1'b0;
  endtask

  // IF/ID monitor: every enabled load must match the next scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && ifid_en) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_en", {31'd0, ifid_en}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("sb_instr", {16'd0, instr_out}, {16'd0, e.instr});
        check("sb_nextpc", {16'd0, nextPC_out}, {16'd0, e.npc});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; stall_in = 1'b1; redirect = 1'b0; redirect_pc = 16'h0;
    mem_on = 1'b0; lat = 0; halt_addr = 16'hFFFF;

    // reset state
    sample();
    check("rst_rd",     {31'd0, imem_rd}, 32'd0);
    check("rst_en",     {31'd0, ifid_en}, 32'd0);
    check("rst_instr",  {16'd0, instr_out}, 32'h0800);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_addr",   {16'd0, imem_addr}, 32'h0000);
    check("rst_npc",    {16'd0, nextPC_out}, 32'h0002);
    step();

    // zero-wait memory
    rst = 1'b0; stall_in = 1'b0; mem_on = 1'b1; lat = 0;
    push(16'h1111, 16'h0002); push(16'h2222, 16'h0004); push(16'h3333, 16'h0006);
    sample();
    check("zw_first_rd",   {31'd0, imem_rd}, 32'd1);
    check("zw_first_addr", {16'd0, imem_addr}, 32'h0000);
    step(); step();
    step(); stall_in = 1'b1; mem_on = 1'b0;
    sample();
    check("zw_drain", sb_q.size(), 32'd0);

    // two-cycle memory
    apply_reset();
    mem_on = 1'b1; lat = 1; stall_in = 1'b0;
    push(16'h0800, 16'h0002); push(16'h1111, 16'h0002);
    push(16'h0800, 16'h0004); push(16'h2222, 16'h0004);
    push(16'h0800, 16'h0006); push(16'h3333, 16'h0006);
    step(); step();
    sample();
    check("lat2_addr", {16'd0, imem_addr}, 32'h0002);
    step(); step(); step();
    step(); stall_in = 1'b1; mem_on = 1'b0;
    sample();
    check("lat2_drain", sb_q.size(), 32'd0);

    // done while stalled, delivered from ibuf
    apply_reset();
    mem_on = 1'b1; lat = 0; stall_in = 1'b1;
    sample();
    check("stall0_en", {31'd0, ifid_en}, 32'd0);
    for (int i = 1; i < 3; i++) begin
      step();
      sample();
      check("stall_en", {31'd0, ifid_en}, 32'd0);
      check("stall_rd", {31'd0, imem_rd}, 32'd0);
    end
    step(); stall_in = 1'b0;
    push(16'h1111, 16'h0002); push(16'h2222, 16'h0004);
    sample();
    check("ibuf_exit_rd", {31'd0, imem_rd}, 32'd0);
    step();
    sample();
    check("post_ibuf_rd",   {31'd0, imem_rd}, 32'd1);
    check("post_ibuf_addr", {16'd0, imem_addr}, 32'h0002);
    step(); stall_in = 1'b1; mem_on = 1'b0;
    sample();
    check("stall_drain", sb_q.size(), 32'd0);

    // redirect during an outstanding request
    apply_reset();
    redirect = 1'b1; redirect_pc = 16'h0010; mem_on = 1'b1; lat = 0; stall_in = 1'b0;
    push(16'h0800, 16'h0002);
    step();
    redirect_pc = 16'h0040; lat = 2;
    push(16'h0800, 16'h0012);
    sample();
    check("sq_addr0", {16'd0, imem_addr}, 32'h0010);
    step(); redirect = 1'b0;
    push(16'h0800, 16'h0012);
    sample();
    check("sq_addr1", {16'd0, imem_addr}, 32'h0010);
    check("sq_rd1",   {31'd0, imem_rd}, 32'd1);
    check("sq_done1", {31'd0, imem_done}, 32'd0);
    step();
    push(16'h0800, 16'h0012);
    sample();
    check("sq_done2", {31'd0, imem_done}, 32'd1);
    check("sq_addr2", {16'd0, imem_addr}, 32'h0010);
    step(); stall_in = 1'b1; mem_on = 1'b0;
    sample();
    check("sq_new_rd",   {31'd0, imem_rd}, 32'd1);
    check("sq_new_addr", {16'd0, imem_addr}, 32'h0040);
    check("sq_drain", sb_q.size(), 32'd0);

    // halt and restart by redirect
    apply_reset();
    halt_addr = 16'h0006; mem_on = 1'b1; lat = 0; stall_in = 1'b0;
    push(16'h1111, 16'h0002); push(16'h2222, 16'h0004); push(16'h3333, 16'h0006);
    push(16'h0000, 16'h0008); push(16'h0800, 16'h000A); push(16'h0800, 16'h000A);
    push(16'h0800, 16'h000A);
    step(); step(); step();
    sample();
    check("pre_halt", {31'd0, halted}, 32'd0);
    step();
    sample();
    check("halted",    {31'd0, halted}, 32'd1);
    check("halted_rd", {31'd0, imem_rd}, 32'd0);
    step();
    step(); redirect = 1'b1; redirect_pc = 16'h0100;
    step(); redirect = 1'b0; stall_in = 1'b1; mem_on = 1'b0;
    sample();
    check("unhalt",      {31'd0, halted}, 32'd0);
    check("unhalt_rd",   {31'd0, imem_rd}, 32'd1);
    check("unhalt_addr", {16'd0, imem_addr}, 32'h0100);
    check("halt_drain", sb_q.size(), 32'd0);
    halt_addr = 16'hFFFF;

    // reset mid-request, then wrap at 0xFFFE
    apply_reset();
    redirect = 1'b1; redirect_pc = 16'h0020; mem_on = 1'b1; lat = 0; stall_in = 1'b0;
    push(16'h0800, 16'h0002);
    step(); redirect = 1'b0; mem_on = 1'b0;
    push(16'h0800, 16'h0022);
    sample();
    check("mid_addr", {16'd0, imem_addr}, 32'h0020);
    step(); rst = 1'b1;
    #1;
    check("mid_rst_rd",    {31'd0, imem_rd}, 32'd0);
    check("mid_rst_instr", {16'd0, instr_out}, 32'h0800);
    check("mid_rst_en",    {31'd0, ifid_en}, 32'd0);
    check("mid_rst_addr",  {16'd0, imem_addr}, 32'h0000);
    check("mid_rst_npc",   {16'd0, nextPC_out}, 32'h0002);
    step(); rst = 1'b0;
    redirect = 1'b1; redirect_pc = 16'hFFFE; mem_on = 1'b1; stall_in = 1'b0;
    push(16'h0800, 16'h0002);
    sample();
    check("post_rst_rd",   {31'd0, imem_rd}, 32'd1);
    check("post_rst_addr", {16'd0, imem_addr}, 32'h0000);
    step(); redirect = 1'b0;
    push(16'hAFFE, 16'h0000);
    sample();
    check("wrap_addr", {16'd0, imem_addr}, 32'hFFFE);
    check("wrap_npc",  {16'd0, nextPC_out}, 32'h0000);
    step(); stall_in = 1'b1; mem_on = 1'b0;
    sample();
    check("wrap_pc", {16'd0, imem_addr}, 32'h0000);
    check("wrap_drain", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction-fetch stage for the 16-bit pipelined core. Holds the PC and runs a single-outstanding request/done handshake with instruction memory, including variable-latency memory. Produces the instruction word, PC+2 and the load enable for the IF/ID pipeline register. Inserts NOP (0x0800) bubbles on memory latency, flush and halt, and resolves redirects from later stages, including redirects that arrive while a fetch is in flight.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset
- NOP_INSTR, 16'h0800, bubble instruction driven into IF/ID
- HALT_OPC, 5'b00000, opcode (instr[15:11]) that stops fetching

- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- stall_in  in  1  IF/ID must hold (decode-side hazard stall)
- redirect  in  1  branch/jump taken; fetch must restart at redirect_pc
- redirect_pc  in  16  redirect target
- imem_rd  out  1  read request; held high until imem_done
- imem_addr  out  16  request address (= pc)
- imem_rdata  in  16  instruction word, valid only when imem_done=1
- imem_done  in  1  memory completes request this cycle (may occur in the same cycle as imem_rd)
- instr_out  out  16  instruction for IF/ID
- nextPC_out  out  16  pc+2 for IF/ID
- ifid_en  out  1  IF/ID load enable
- halted  out  1  fetch stopped on HALT_OPC

## Operation
- State: pc[15:0], ibuf[15:0], redir_pc[15:0], squash bit, FSM {FETCH, WAIT_DS, HALT}.
- nextPC_out = pc+2, modulo 2^16 (0xFFFE → 0x0000). It is driven in every state.
- Decision order each cycle: rst, then redirect, then imem_done, then stall_in.
- FETCH behaviour:
  - Drives imem_rd=1, imem_addr=pc.
  - done, squash=0, stall_in=0: instr_out=imem_rdata, ifid_en=1, pc←pc+2. Next state is HALT if imem_rdata[15:11]==HALT_OPC, else FETCH.
  - done, squash=0, stall_in=1: ibuf←imem_rdata, ifid_en=0, pc unchanged, go to WAIT_DS.
  - done, squash=1: data dropped, pc←redir_pc, squash←0, stay in FETCH. instr_out=NOP, ifid_en=!stall_in.
  - not done: instr_out=NOP, ifid_en=!stall_in (bubble).
- WAIT_DS behaviour:
  - imem_rd=0, instr_out=ibuf, ifid_en=!stall_in.
  - On !stall_in: pc←pc+2. Next state is HALT if ibuf[15:11]==HALT_OPC, else FETCH.
- HALT behaviour:
  - imem_rd=0, halted=1, instr_out=NOP, ifid_en=!stall_in.
  - Left only by redirect or rst.
- Redirect (any state) is a flush and overrides stall_in: instr_out=NOP, ifid_en=1.
  - FETCH with a request outstanding and imem_done=0: the request cannot be withdrawn. redir_pc←redirect_pc, squash←1. imem_rd and imem_addr stay unchanged until done.
  - FETCH with imem_done=1 in the same cycle: data dropped, pc←redirect_pc, squash stays 0.
  - WAIT_DS or HALT: ibuf discarded, pc←redirect_pc, go to FETCH.
  - Redirect while squash=1: redir_pc overwritten; the latest target wins.
- The halt instruction itself is delivered to IF/ID; fetching stops after it.

## Timing
- Reset (asynchronous, immediate): pc=RESET_PC, state=FETCH, squash=0, ibuf=NOP_INSTR, redir_pc=RESET_PC.
- While rst=1, outputs are: imem_rd=0, ifid_en=0, instr_out=NOP_INSTR, halted=0, imem_addr=RESET_PC, nextPC_out=RESET_PC+2.
- First cycle after rst deasserts: imem_rd=1, imem_addr=RESET_PC.
- Zero-wait memory (done in the same cycle as rd): one instruction per cycle, no bubbles.
- N-cycle memory: N-1 NOP bubbles per instruction, plus one cycle with imem_rd=0 after each WAIT_DS exit.
- Redirect: target is requested on the cycle after the redirect, or the cycle after the squashed done.
- imem_addr is stable for the whole request. It never changes while imem_rd=1 and done=0.
- rst mid-request: the request is abandoned; memory must tolerate imem_rd dropping.

## Test plan
- Zero-wait memory returns 0x1111, 0x2222, 0x3333 from RESET_PC=0 → ifid_en=1 on three consecutive cycles; instr_out matches the words; nextPC_out=0x0002, 0x0004, 0x0006.
- Two-cycle memory latency → each instruction is preceded by exactly one NOP (0x0800) with ifid_en=1; pc advances by 2 per completed fetch.
- Done with stall_in=1 for 3 cycles → ifid_en=0 for 3 cycles, no new imem_rd; instruction delivered from ibuf on the first cycle with stall_in=0, then a fetch at pc+2.
- Redirect to 0x0040 while a request to 0x0010 is outstanding (done 2 cycles later) → imem_addr holds 0x0010 until done; that data is dropped and NOPs are delivered; the next request is at 0x0040.
- Fetch of 0x0000 (HALT) → halt instruction delivered, halted=1, imem_rd=0 thereafter, NOPs delivered. Redirect to 0x0100 → halted=0 and a request at 0x0100.
- Assert rst mid-request at pc=0x0020 → immediately imem_rd=0, instr_out=0x0800, ifid_en=0; after release, a request at RESET_PC. Also cover the wrap case pc=0xFFFE → nextPC_out=0x0000.
